mem_arbiter_rr: RTL and testbench
=================================

// Module: mem_arbiter_rr
// PURPOSE
//  Parametrised N-port arbiter between the cache miss/writeback channels (Icache read, Dcache read, Dcache write, ...)
//  and the single synchronous memory port. Replaces the fixed 3-channel arbiter in the cpu top level.
//  Supports fixed-priority or round-robin selection and an optional memory watchdog that reports errors.
//  Exactly one memory transaction is outstanding at any time.
// PARAMETERS
//  NUM_PORTS  3    number of requesters (>=2); port 0 = Icache read, 1 = Dcache read, 2 = Dcache write
//  ADDR_W     32   address width
//  DATA_W     128  memory line width (BWIDTH)
//  ARB_MODE   1    0 = fixed priority (lowest index wins), 1 = round-robin
//  TIMEOUT    0    max cycles waiting for mem_ack; 0 = watchdog disabled
// PORTS
//  clk           in   1                 clock, all state on rising edge
//  reset         in   1                 asynchronous, active-high
//  req           in   NUM_PORTS         per-port request; held until that port's ack
//  req_rw        in   NUM_PORTS         per-port 1 = write, 0 = read
//  req_addr      in   NUM_PORTS*ADDR_W  port i occupies [i*ADDR_W +: ADDR_W]
//  req_wdata     in   NUM_PORTS*DATA_W  port i occupies [i*DATA_W +: DATA_W]
//  ack           out  NUM_PORTS         one-cycle completion pulse per port
//  err           out  NUM_PORTS         valid with ack; 1 = watchdog abort
//  rdata         out  DATA_W            read line, valid while any ack bit is high
//  grant_id      out  $clog2(NUM_PORTS) index of the port currently owning memory
//  busy          out  1                 1 in BUSY and RESP states
//  mem_enable    out  1                 memory request, held high for the whole transaction
//  mem_rw        out  1                 1 = write
//  mem_ack       in   1                 memory completion, single cycle
//  mem_addr      out  ADDR_W            memory address
//  mem_data_out  in   DATA_W            data from memory
//  mem_data_in   out  DATA_W            data to memory
// BEHAVIOUR
//  - All outputs are registered. Reset drives state=IDLE, rr_ptr=0, timer=0, and every output to 0.
//  - Reset asserted mid-transaction aborts the transaction. No ack is ever issued for it.
//  - FSM IDLE: if any req bit is set, the picker selects winner g.
//      The arbiter latches grant_id=g and drives mem_addr/mem_rw/mem_data_in from port g, then goes to BUSY.
//      mem_enable=1 from the next cycle. mem_ack seen in IDLE is ignored.
//  - FSM BUSY: the memory outputs stay frozen at the latched values.
//      On mem_ack: capture mem_data_out into rdata (reads only; writes leave rdata unchanged).
//      Then set ack[g]=1, mem_enable=0, and go to RESP.
//      Watchdog (TIMEOUT>0): timer counts cycles in BUSY. When timer==TIMEOUT-1 without mem_ack,
//      set ack[g]=1, err[g]=1, mem_enable=0, and go to RESP.
//      A mem_ack arriving in the same cycle as the timeout wins (err=0).
//  - FSM RESP: ack/err are held for exactly one cycle, then cleared; go to IDLE.
//      Port g's req is not sampled in RESP. The requester drops req the cycle after ack.
//  - Latency: req rising at cycle 0 gives mem_enable at cycle 1. mem_ack at cycle k (k>=1) gives ack at k+1.
//      Back-to-back grants are separated by at least one IDLE cycle.
//  - Fixed mode: the lowest-index asserted req wins.
//  - Round-robin mode: search starts at rr_ptr. rr_ptr <= (g+1) mod NUM_PORTS on each grant,
//      with wrap from NUM_PORTS-1 to 0. A watchdog abort still advances rr_ptr.
//  - Starvation bound in round-robin: at most NUM_PORTS-1 grants to other ports before port i wins.
//  - Requester inputs of non-granted ports are don't-care. A req drop while granted is ignored;
//      the transaction completes.
// STRUCTURE
//  - define.v: ARB_FIXED/ARB_RR mode constants and FSM state encodings (ARB_IDLE, ARB_BUSY, ARB_RESP).
//  - Sub-module rr_priority_picker (combinational): inputs req vector and start pointer;
//      outputs valid and winner index. Fixed mode instantiates it with start=0.
//  - Top: FSM, grant/payload registers, watchdog counter, output registers.
// TESTING
//  1. Reset mid-BUSY: grant port 1, assert reset before mem_ack -> all outputs 0; no ack[1]; IDLE afterwards.
//  2. Single read, port 0, addr 0x100, mem_ack after 3 cycles with data 0xA5..A5
//       -> mem_enable high 3 cycles; ack[0] one cycle later; rdata=0xA5..A5; err=0.
//  3. Round-robin: req=3'b111 held, each grant acked in 1 cycle -> grant order 0,1,2,0.
//       Same stimulus in fixed mode -> grant order 0,0,0 until port 0 drops req.
//  4. Write, port 2, addr 0x40, wdata 0x1234 -> mem_rw=1, mem_addr=0x40, mem_data_in=0x1234;
//       rdata unchanged; ack[2] pulses.
//  5. Watchdog, TIMEOUT=8, mem_ack never arrives -> ack[g]=1, err[g]=1 eight cycles after mem_enable rises;
//       rr_ptr advances.
//  6. mem_ack in the timeout cycle -> err=0, data captured; stray mem_ack in IDLE -> no ack, no state change.

Source files
------------

// File: rtl/mem_arbiter_rr_pkg.sv
// Shared constants and FSM encoding for the N-port memory arbiter.
package mem_arbiter_rr_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first asserted request at or after start_i, wrapping.
module mem_arbiter_rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] winner_o
);

  logic [IDX_W-1:0] idx;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(start_i) + k) % N);
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port arbiter in front of a single memory port; one transaction outstanding, optional watchdog.
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int ARB_MODE  = 1,
  parameter int TIMEOUT   = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           req,
  input  logic [NUM_PORTS-1:0]           req_rw,
  input  logic [NUM_PORTS*ADDR_W-1:0]    req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]    req_wdata,
  output logic [NUM_PORTS-1:0]           ack,
  output logic [NUM_PORTS-1:0]           err,
  output logic [DATA_W-1:0]              rdata,
  output logic [$clog2(NUM_PORTS)-1:0]   grant_id,
  output logic                           busy,
  output logic                           mem_enable,
  output logic                           mem_rw,
  input  logic                           mem_ack,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic [DATA_W-1:0]              mem_data_out,
  output logic [DATA_W-1:0]              mem_data_in
);

  localparam int IDX_W    = $clog2(NUM_PORTS);
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int TMR_W    = (TMO_LAST > 0) ? $clog2(TMO_LAST + 1) : 1;

  arb_state_e             state_q;
  logic [IDX_W-1:0]       grant_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       rr_ptr_d;
  logic [TMR_W-1:0]       timer_q;
  logic [NUM_PORTS-1:0]   ack_q;
  logic [NUM_PORTS-1:0]   err_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   rw_q;
  logic                   enable_q;
  logic                   busy_q;

  logic [IDX_W-1:0]       pick_start;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic                   sel_rw;
  logic                   timeout_hit;

  // Fixed priority is the same search pinned to start at port 0.
  assign pick_start = (ARB_MODE == ARB_FIXED) ? '0 : rr_ptr_q;

  mem_arbiter_rr_picker #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i    (req),
    .start_i  (pick_start),
    .valid_o  (pick_valid),
    .winner_o (pick_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rw    = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pick_idx == IDX_W'(p)) begin
        sel_addr  = req_addr[p*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[p*DATA_W +: DATA_W];
        sel_rw    = req_rw[p];
      end
    end
  end

  assign rr_ptr_d    = (pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : pick_idx + IDX_W'(1);
  assign timeout_hit = (TIMEOUT > 0) && (timer_q == TMR_W'(TMO_LAST));

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      timer_q  <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant_q  <= pick_idx;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            rw_q     <= sel_rw;
            rr_ptr_q <= rr_ptr_d;
            timer_q  <= '0;
            enable_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // A completion in the timeout cycle takes precedence over the abort.
          if (mem_ack) begin
            if (!rw_q) rdata_q <= mem_data_out;
            ack_q    <= NUM_PORTS'(1) << grant_q;
            enable_q <= 1'b0;
            timer_q  <= '0;
            state_q  <= ARB_RESP;
          end else if (timeout_hit) begin
            ack_q    <= NUM_PORTS'(1) << grant_q;
            err_q    <= NUM_PORTS'(1) << grant_q;
            enable_q <= 1'b0;
            timer_q  <= '0;
            state_q  <= ARB_RESP;
          end else if (TIMEOUT > 0) begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        ARB_RESP: begin
          ack_q   <= '0;
          err_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign mem_enable  = enable_q;
  assign mem_rw      = rw_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: instance 0 is round-robin with an 8-cycle watchdog, instance 1 is fixed priority.
module tb_mem_arbiter_rr;

  localparam int NP = 3;
  localparam int AW = 16;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP-1:0]    req          [2];
  logic [NP-1:0]    req_rw       [2];
  logic [NP*AW-1:0] req_addr     [2];
  logic [NP*DW-1:0] req_wdata    [2];
  logic             mem_ack      [2];
  logic [DW-1:0]    mem_data_out [2];
  logic [NP-1:0]    ack          [2];
  logic [NP-1:0]    err          [2];
  logic [DW-1:0]    rdata        [2];
  logic [1:0]       grant_id     [2];
  logic             busy         [2];
  logic             mem_enable   [2];
  logic             mem_rw       [2];
  logic [AW-1:0]    mem_addr     [2];
  logic [DW-1:0]    mem_data_in  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_arbiter_rr #(
      .NUM_PORTS (NP),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .ARB_MODE  ((gi == 0) ? 1 : 0),
      .TIMEOUT   ((gi == 0) ? 8 : 0)
    ) u_dut (
      .clk          (clk),
      .reset        (rst),
      .req          (req[gi]),
      .req_rw       (req_rw[gi]),
      .req_addr     (req_addr[gi]),
      .req_wdata    (req_wdata[gi]),
      .ack          (ack[gi]),
      .err          (err[gi]),
      .rdata        (rdata[gi]),
      .grant_id     (grant_id[gi]),
      .busy         (busy[gi]),
      .mem_enable   (mem_enable[gi]),
      .mem_rw       (mem_rw[gi]),
      .mem_ack      (mem_ack[gi]),
      .mem_addr     (mem_addr[gi]),
      .mem_data_out (mem_data_out[gi]),
      .mem_data_in  (mem_data_in[gi])
    );
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: rotating pointer and last read line per instance.
  int            m_ptr   [2];
  logic [DW-1:0] m_rdata [2];
  logic [AW-1:0] t_addr  [2][NP];
  logic [DW-1:0] t_wdata [2][NP];
  logic          t_rw    [2][NP];
  logic [NP-1:0] pend    [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin: walk ports starting at the pointer; fixed: lowest index requesting.
  function automatic int model_pick(input int sel, input logic [NP-1:0] r);
    int start;
    start = (sel == 0) ? m_ptr[0] : 0;
    for (int k = 0; k < NP; k++) begin
      if (r[(start + k) % NP]) return (start + k) % NP;
    end
    return -1;
  endfunction

  task automatic drive_payload(input int sel);
    for (int p = 0; p < NP; p++) begin
      req_rw[sel][p]             = t_rw[sel][p];
      req_addr[sel][p*AW +: AW]  = t_addr[sel][p];
      req_wdata[sel][p*DW +: DW] = t_wdata[sel][p];
    end
  endtask

  task automatic rand_payload(input int sel);
    for (int p = 0; p < NP; p++) begin
      t_addr[sel][p]  = AW'($urandom);
      t_wdata[sel][p] = {$urandom, $urandom};
      t_rw[sel][p]    = 1'($urandom_range(0, 1));
    end
    drive_payload(sel);
  endtask

  task automatic check_quiet(input string tag, input int sel);
    check({tag, "_ack"}, 64'(ack[sel]), 64'(0));
    check({tag, "_err"}, 64'(err[sel]), 64'(0));
    check({tag, "_busy"}, 64'(busy[sel]), 64'(0));
    check({tag, "_men"}, 64'(mem_enable[sel]), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req[s] = '0; req_rw[s] = '0; req_addr[s] = '0; req_wdata[s] = '0;
      mem_ack[s] = 1'b0; mem_data_out[s] = '0;
      m_ptr[s] = 0; m_rdata[s] = '0; pend[s] = '0;
    end
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      check_quiet("rst", s);
      check("rst_rdata", rdata[s], m_rdata[s]);
      check("rst_gid", 64'(grant_id[s]), 64'(0));
      check("rst_maddr", 64'(mem_addr[s]), 64'(0));
    end
    rst = 1'b0;
  endtask

  // Runs one arbitration from IDLE. lat = BUSY cycle (0-based) on which mem_ack is high.
  task automatic run_txn(input int sel, input int lat, input logic stray, input logic [DW-1:0] data,
                         output int g_out, output int busy_cycles);
    int tmo;
    int g;
    bit done;
    bit ack_now;
    bit to_now;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          erw;
    tmo  = (sel == 0) ? 8 : 0;
    done = 1'b0;
    busy_cycles = 0;
    g = model_pick(sel, req[sel]);
    g_out = g;
    mem_ack[sel] = stray;
    tick();
    mem_ack[sel] = 1'b0;
    if (g < 0) begin
      check_quiet("idle", sel);
      return;
    end
    ea = t_addr[sel][g]; ed = t_wdata[sel][g]; erw = t_rw[sel][g];
    check("grant_id", 64'(grant_id[sel]), 64'(g));
    check("grant_men", 64'(mem_enable[sel]), 64'(1));
    check("grant_busy", 64'(busy[sel]), 64'(1));
    check("grant_addr", 64'(mem_addr[sel]), 64'(ea));
    check("grant_rw", 64'(mem_rw[sel]), 64'(erw));
    check("grant_wdata", mem_data_in[sel], ed);
    check("grant_ack", 64'(ack[sel]), 64'(0));
    if (sel == 0) m_ptr[0] = (g + 1) % NP;
    for (int b = 0; b < 40 && !done; b++) begin
      ack_now = (b == lat);
      to_now  = (tmo > 0) && (b == tmo - 1);
      mem_ack[sel] = ack_now;
      mem_data_out[sel] = ack_now ? data : {$urandom, $urandom};
      rand_payload(sel);
      tick();
      busy_cycles = b + 1;
      if (ack_now || to_now) begin
        done = 1'b1;
        if (ack_now && !erw) m_rdata[sel] = data;
        check("done_ack", 64'(ack[sel]), 64'(1 << g));
        check("done_err", 64'(err[sel]), ack_now ? 64'(0) : 64'(1 << g));
        check("done_rdata", rdata[sel], m_rdata[sel]);
        check("done_men", 64'(mem_enable[sel]), 64'(0));
        check("done_busy", 64'(busy[sel]), 64'(1));
      end else begin
        check("hold_men", 64'(mem_enable[sel]), 64'(1));
        check("hold_ack", 64'(ack[sel]), 64'(0));
        check("hold_addr", 64'(mem_addr[sel]), 64'(ea));
        check("hold_wdata", mem_data_in[sel], ed);
        check("hold_gid", 64'(grant_id[sel]), 64'(g));
      end
    end
    check("txn_done", 64'(done), 64'(1));
    mem_ack[sel] = 1'b0;
    req[sel][g] = 1'b0;
    tick();
    check_quiet("resp_end", sel);
  endtask

  int g;
  int bc;
  int exp_rr [4] = '{0, 1, 2, 0};
  logic [DW-1:0] keep;
  logic [DW-1:0] a5 = {8{8'hA5}};

  initial begin
    // Reset state.
    do_reset();

    // Reset mid-BUSY aborts port 1 with no ack.
    rand_payload(0);
    req[0] = 3'b010;
    tick();
    check("rb_gid", 64'(grant_id[0]), 64'(1));
    check("rb_men", 64'(mem_enable[0]), 64'(1));
    tick();
    rst = 1'b1;
    #1;
    check_quiet("rb_async", 0);
    check("rb_gid0", 64'(grant_id[0]), 64'(0));
    req[0] = '0;
    tick();
    rst = 1'b0;
    m_ptr[0] = 0; m_rdata[0] = '0;
    tick();
    check_quiet("rb_after1", 0);
    tick();
    check_quiet("rb_after2", 0);

    // Single read, port 0, addr 0x100, ack on the third enable cycle.
    rand_payload(0);
    t_addr[0][0] = 16'h0100; t_rw[0][0] = 1'b0;
    drive_payload(0);
    req[0] = 3'b001;
    run_txn(0, 2, 1'b0, a5, g, bc);
    check("rd_enable_cycles", 64'(bc), 64'(3));
    check("rd_rdata", rdata[0], a5);

    // Round-robin order with all requests held.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rand_payload(0);
      req[0] = 3'b111;
      run_txn(0, 0, 1'b0, {$urandom, $urandom}, g, bc);
      check("rr_order", 64'(g), 64'(exp_rr[i]));
    end
    req[0] = '0;

    // Fixed priority keeps picking port 0 until it drops.
    for (int i = 0; i < 3; i++) begin
      rand_payload(1);
      req[1] = 3'b111;
      run_txn(1, 0, 1'b0, {$urandom, $urandom}, g, bc);
      check("fx_order", 64'(g), 64'(0));
    end
    rand_payload(1);
    req[1] = 3'b110;
    run_txn(1, 1, 1'b0, {$urandom, $urandom}, g, bc);
    check("fx_next", 64'(g), 64'(1));

    // Write on port 2: rdata stays put.
    keep = m_rdata[1];
    rand_payload(1);
    t_addr[1][2] = 16'h0040; t_wdata[1][2] = 64'h1234; t_rw[1][2] = 1'b1;
    drive_payload(1);
    req[1] = 3'b100;
    run_txn(1, 1, 1'b0, {$urandom, $urandom}, g, bc);
    check("wr_port", 64'(g), 64'(2));
    check("wr_rdata_keep", rdata[1], keep);

    // Watchdog: no mem_ack, abort eight cycles after enable rises; pointer still advances.
    rand_payload(0);
    req[0] = 3'b001;
    run_txn(0, 100, 1'b0, '0, g, bc);
    check("wd_cycles", 64'(bc), 64'(8));
    rand_payload(0);
    req[0] = 3'b111;
    run_txn(0, 0, 1'b0, {$urandom, $urandom}, g, bc);
    check("wd_ptr_adv", 64'(g), 64'(1));

    // mem_ack in the timeout cycle wins.
    rand_payload(0);
    t_rw[0][2] = 1'b0;
    drive_payload(0);
    req[0] = 3'b111;
    run_txn(0, 7, 1'b0, 64'h00C0_FFEE_1234_5678, g, bc);
    check("tmo_race_port", 64'(g), 64'(2));
    check("tmo_race_rdata", rdata[0], 64'h00C0_FFEE_1234_5678);

    // Stray mem_ack in IDLE does nothing.
    req[0] = '0;
    run_txn(0, 0, 1'b1, '0, g, bc);
    check("stray_nogrant", 64'(g), 64'hFFFF_FFFF_FFFF_FFFF);
    rand_payload(0);
    req[0] = 3'b111;
    run_txn(0, 0, 1'b0, {$urandom, $urandom}, g, bc);
    check("stray_ptr", 64'(g), 64'(0));
    req[0] = '0;

    // Randomized traffic on both instances, one active at a time.
    for (int i = 0; i < 200; i++) begin
      int sel;
      sel = $urandom_range(0, 1);
      req[sel] = pend[sel] | NP'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) req[sel] = '0;
      rand_payload(sel);
      run_txn(sel, $urandom_range(0, 10), 1'($urandom_range(0, 1)), {$urandom, $urandom}, g, bc);
      pend[sel] = req[sel];
      req[sel]  = '0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
